// File: rtl/busca_instrucao.sv
// ============================================================================
// busca_instrucao: RV32I instruction fetch over a req/ack handshake, with
// field extraction, stall hold and branch redirect.
// Optional build macro: FETCH_COUNT_EN (adds instr_count output).
// Revision: 1.0
// ============================================================================
`default_nettype none

module busca_instrucao #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              valid,
  output logic [2:0]        tipo,
  output logic [2:0]        funct3,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [31:0]       imm,
  output logic [ADDR_W-1:0] pc_out,
  output logic              illegal
`ifdef FETCH_COUNT_EN
  ,
  output logic [31:0]       instr_count
`endif
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        dec_tipo;
  logic [31:0]       dec_imm;
  logic              dec_illegal;
  logic              unused_bits;

  assign imem_req  = (state == FETCH) && !rst;
  assign imem_addr = pc;

  // Opcode bits [3:2] are not needed to tell the supported classes apart.
  assign unused_bits = ^imem_rdata[3:2];

  assign dec_tipo = imem_rdata[6:4];

  always_comb begin
    dec_imm = '0;
    case (dec_tipo)
      3'b000:  dec_imm = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
      3'b010:  dec_imm = {{20{imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};
      3'b110:  dec_imm = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                          imem_rdata[30:25], imem_rdata[11:8], 1'b0};
      default: dec_imm = '0;
    endcase
  end

  always_comb begin
    dec_illegal = (imem_rdata[1:0] != 2'b11) ||
                  !((dec_tipo == 3'b000) || (dec_tipo == 3'b010) ||
                    (dec_tipo == 3'b011) || (dec_tipo == 3'b110));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      valid   <= 1'b0;
      tipo    <= '0;
      funct3  <= '0;
      rd      <= '0;
      rs1     <= '0;
      rs2     <= '0;
      imm     <= '0;
      pc_out  <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            tipo    <= dec_tipo;
            funct3  <= imem_rdata[14:12];
            rd      <= imem_rdata[11:7];
            rs1     <= imem_rdata[19:15];
            rs2     <= imem_rdata[24:20];
            imm     <= dec_imm;
            illegal <= dec_illegal;
            pc_out  <= pc;
            valid   <= 1'b1;
            state   <= ISSUE;
          end
        end
        default: begin
          // Fields stay frozen after valid drops so consumers see stable values.
          if (!stall) begin
            pc    <= branch_taken ? branch_target : pc + PC_STEP;
            valid <= 1'b0;
            state <= FETCH;
          end
        end
      endcase
    end
  end

`ifdef FETCH_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_count <= '0;
    end else if ((state == ISSUE) && !stall) begin
      instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_busca_instrucao.sv
// ============================================================================
// tb_busca_instrucao: directed self-checking bench for busca_instrucao.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_busca_instrucao;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        valid;
  logic [2:0]  tipo;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic [31:0] pc_out;
  logic        illegal;
`ifdef FETCH_COUNT_EN
  logic [31:0] instr_count;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] LW  = 32'h0080A283;
  localparam logic [31:0] SUB = 32'h402081B3;
  localparam logic [31:0] BEQ = 32'hFE208CE3;
  localparam logic [31:0] SW  = 32'hFE112E23;
  localparam logic [31:0] ADI = 32'h00000013;

  always #5 clk = ~clk;

  busca_instrucao dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .valid        (valid),
    .tipo         (tipo),
    .funct3       (funct3),
    .rd           (rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .imm          (imm),
    .pc_out       (pc_out),
    .illegal      (illegal)
`ifdef FETCH_COUNT_EN
    ,
    .instr_count  (instr_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (2) tick();
    check("rst_valid", valid, 0);
    check("rst_tipo", tipo, 0);
    check("rst_req", imem_req, 0);
    check("rst_pc_out", pc_out, 0);
    check("rst_imm", imm, 0);
    check("rst_illegal", illegal, 0);
`ifdef FETCH_COUNT_EN
    check("rst_count", instr_count, 0);
`endif
    rst = 1'b0; #1;
    check("first_req", imem_req, 1);
    check("first_addr", imem_addr, 0);
    imem_ack = 1'b1; imem_rdata = LW;

    tick(); imem_ack = 1'b0;
    check("lw_valid", valid, 1);
    check("lw_tipo", tipo, 3'b000);
    check("lw_funct3", funct3, 3'b010);
    check("lw_rd", rd, 5);
    check("lw_rs1", rs1, 1);
    check("lw_rs2", rs2, 8);
    check("lw_imm", imm, 32'h8);
    check("lw_illegal", illegal, 0);
    check("lw_pc_out", pc_out, 0);
    check("lw_req_low", imem_req, 0);

    tick();
    check("b2b_valid", valid, 0);
    check("b2b_req", imem_req, 1);
    check("b2b_addr", imem_addr, 4);
    check("hold_rd", rd, 5);
    imem_ack = 1'b1; imem_rdata = SUB;

    tick(); imem_ack = 1'b0;
    check("sub_tipo", tipo, 3'b011);
    check("sub_funct3", funct3, 0);
    check("sub_rd", rd, 3);
    check("sub_rs1", rs1, 1);
    check("sub_rs2", rs2, 2);
    check("sub_imm", imm, 0);
    check("sub_pc_out", pc_out, 4);

    tick();
    check("beq_addr", imem_addr, 8);
    imem_ack = 1'b1; imem_rdata = BEQ;

    tick(); imem_ack = 1'b0;
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    check("beq_tipo", tipo, 3'b110);
    check("beq_imm", imm, 32'hFFFFFFF8);
    check("beq_pc_out", pc_out, 8);
    check("beq_illegal", illegal, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", valid, 1);
      check("stall_imm", imm, 32'hFFFFFFF8);
      check("stall_tipo", tipo, 3'b110);
      check("stall_pc_out", pc_out, 8);
      check("stall_req", imem_req, 0);
    end
    stall = 1'b0; branch_taken = 1'b1; branch_target = 32'h0;

    tick(); branch_taken = 1'b0;
    check("br_valid", valid, 0);
    check("br_req", imem_req, 1);
    check("br_addr", imem_addr, 0);
    imem_ack = 1'b1; imem_rdata = 32'h0;

    tick(); imem_ack = 1'b0;
    check("zero_valid", valid, 1);
    check("zero_illegal", illegal, 1);
    check("zero_tipo", tipo, 0);
    check("zero_pc_out", pc_out, 0);

    tick();
    check("zero_next_addr", imem_addr, 4);
    imem_ack = 1'b1; imem_rdata = ADI;

    tick(); imem_ack = 1'b0;
    check("addi_illegal", illegal, 1);
    check("addi_tipo", tipo, 3'b001);
    check("addi_imm", imm, 0);

    tick();
    check("sw_addr", imem_addr, 8);
    imem_ack = 1'b1; imem_rdata = SW;

    tick(); imem_ack = 1'b0;
    check("sw_tipo", tipo, 3'b010);
    check("sw_funct3", funct3, 3'b010);
    check("sw_rs1", rs1, 2);
    check("sw_rs2", rs2, 1);
    check("sw_imm", imm, 32'hFFFFFFFC);
    branch_taken = 1'b1; branch_target = 32'hFFFFFFFC;

    tick(); branch_taken = 1'b0;
    check("top_addr", imem_addr, 32'hFFFFFFFC);
    imem_ack = 1'b1; imem_rdata = SUB;

    tick(); imem_ack = 1'b0;
    check("top_pc_out", pc_out, 32'hFFFFFFFC);
    check("top_illegal", illegal, 0);

    tick();
    check("wrap_addr", imem_addr, 0);
    imem_ack = 1'b1; imem_rdata = SUB;

    tick(); imem_ack = 1'b0;
    check("wrap_pc_out", pc_out, 0);

    tick();
    check("pre_rst_addr", imem_addr, 4);
`ifdef FETCH_COUNT_EN
    check("count_8", instr_count, 8);
`endif
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = BEQ;

    tick(); rst = 1'b0; imem_ack = 1'b0; #1;
    check("mid_rst_valid", valid, 0);
    check("mid_rst_req", imem_req, 1);
    check("mid_rst_addr", imem_addr, 0);
    check("mid_rst_tipo", tipo, 0);
    check("mid_rst_pc_out", pc_out, 0);
`ifdef FETCH_COUNT_EN
    check("count_rst", instr_count, 0);
`endif

    tick();
    check("dropped_ack_valid", valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
